// File: rtl/ahb_pkg.sv
// ahb_pkg: shared AHB transfer/response encodings and helpers
package ahb_pkg;
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;
  localparam logic [1:0] HRESP_OKAY    = 2'b00;
  localparam logic [1:0] HRESP_ERROR   = 2'b01;
  function automatic logic [2:0] onehot_idx(input logic [7:0] v);
    onehot_idx = '0;
    for (int i = 0; i < 8; i++)
      if (v[i]) onehot_idx = 3'(i);
  endfunction
endpackage

// File: rtl/ahb_master_arbiter_rr_picker.sv
// rr_picker: combinational round-robin search starting after the last owner
module rr_picker #(
  parameter int N  = 3,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  gnt,
  output logic          valid
);
  always_comb begin
    gnt = '0;
    for (int i = N; i >= 1; i--)
      if (req[IW'((int'(last) + i) % N)]) gnt = N'(1) << ((int'(last) + i) % N);
  end
  assign valid = |req;
endmodule

// File: rtl/ahb_master_arbiter.sv
// ahb_master_arbiter: round-robin AHB arbiter and address/data mux in front of the APB bridge
module ahb_master_arbiter
  import ahb_pkg::*;
#(
  parameter int NUM_MASTERS = 3,
  parameter int MAX_BEATS   = 4,
  localparam int IW         = $clog2(NUM_MASTERS)
) (
  input  logic                      Hclk,
  input  logic                      Hreset,
  input  logic [NUM_MASTERS-1:0]    Hbusreq,
  input  logic [2*NUM_MASTERS-1:0]  m_Htrans,
  input  logic [32*NUM_MASTERS-1:0] m_Haddr,
  input  logic [NUM_MASTERS-1:0]    m_Hwrite,
  input  logic [32*NUM_MASTERS-1:0] m_Hwdata,
  input  logic                      Hready_out,
  input  logic [1:0]                Hresp,
  output logic [1:0]                Htrans,
  output logic [31:0]               Haddr,
  output logic                      Hwrite,
  output logic [31:0]               Hwdata,
  output logic                      Hready_in,
  output logic [NUM_MASTERS-1:0]    Hgrant,
  output logic [IW-1:0]             Hmaster,
  output logic [IW-1:0]             Hmaster_d
);
  logic [IW-1:0] sel, sel_d, gidx, nidx;
  logic [NUM_MASTERS-1:0] win, gnt_nxt;
  logic [1:0] own_trans;
  logic [3:0] beat_cnt;
  logic win_v, xfer, others, rearb, unused_ok;
  assign unused_ok = ^Hresp;
  assign sel       = Hreset ? '0 : Hmaster;
  assign sel_d     = Hreset ? '0 : Hmaster_d;
  assign own_trans = m_Htrans[2*int'(Hmaster) +: 2];
  assign Htrans    = Hreset ? HTRANS_IDLE : own_trans;
  assign Haddr     = m_Haddr[32*int'(sel) +: 32];
  assign Hwrite    = m_Hwrite[sel];
  assign Hwdata    = m_Hwdata[32*int'(sel_d) +: 32];
  assign Hready_in = Hready_out;
  assign xfer      = own_trans == HTRANS_NONSEQ || own_trans == HTRANS_SEQ;
  assign others    = |(Hbusreq & ~(NUM_MASTERS'(1) << Hmaster));
  assign rearb     = !Hbusreq[Hmaster] || own_trans == HTRANS_IDLE ||
                     (xfer && int'(beat_cnt) >= MAX_BEATS - 1 && others);
  rr_picker #(.N(NUM_MASTERS)) u_pick (
    .req  (Hbusreq),
    .last (Hmaster),
    .gnt  (win),
    .valid(win_v)
  );
  // with no requester the bus parks on master 0
  assign gnt_nxt = !rearb ? Hgrant : win_v ? win : NUM_MASTERS'(1);
  assign gidx    = IW'(onehot_idx(8'(Hgrant)));
  assign nidx    = IW'(onehot_idx(8'(gnt_nxt)));
  always_ff @(posedge Hclk)
    if (Hreset) begin
      Hgrant    <= NUM_MASTERS'(1);
      Hmaster   <= '0;
      Hmaster_d <= '0;
      beat_cnt  <= '0;
    end else if (Hready_out) begin
      Hgrant    <= gnt_nxt;
      Hmaster   <= gidx;
      Hmaster_d <= Hmaster;
      beat_cnt  <= (gidx != Hmaster || (rearb && nidx == Hmaster)) ? '0 :
                   (xfer && int'(beat_cnt) < MAX_BEATS && beat_cnt != 4'hf) ? beat_cnt + 4'd1 : beat_cnt;
    end
endmodule

// File: tb/tb_ahb_master_arbiter.sv
// tb_ahb_master_arbiter: directed scoreboard bench for the round-robin AHB arbiter
module tb_ahb_master_arbiter;
  import ahb_pkg::*;
  localparam logic [1:0] I = HTRANS_IDLE, NS = HTRANS_NONSEQ, SQ = HTRANS_SEQ;
  localparam logic [31:0] A0 = 32'h0000_0a00, A1 = 32'h8000_0004, A2 = 32'h0000_0c08;
  localparam logic [31:0] W0 = 32'h0000_1111, W1 = 32'hdead_beef, W2 = 32'h2222_3333;
  typedef enum {S_GNT, S_M, S_MD, S_TR, S_ADDR, S_WR, S_WD, S_BEAT, S_RDY} sig_e;
  typedef struct {
    string       tag;
    sig_e        s;
    logic [31:0] v;
  } exp_t;
  logic Hclk = 0, Hreset, Hready_out, Hwrite, Hready_in;
  logic [2:0] Hbusreq, m_Hwrite, Hgrant;
  logic [5:0] m_Htrans;
  logic [95:0] m_Haddr, m_Hwdata;
  logic [1:0] Hresp, Htrans, Hmaster, Hmaster_d;
  logic [31:0] Haddr, Hwdata;
  exp_t sb[$];
  int checks = 0, failures = 0;
  always #5 Hclk = ~Hclk;
  ahb_master_arbiter #(.NUM_MASTERS(3), .MAX_BEATS(4)) dut (
    .Hclk(Hclk), .Hreset(Hreset), .Hbusreq(Hbusreq), .m_Htrans(m_Htrans),
    .m_Haddr(m_Haddr), .m_Hwrite(m_Hwrite), .m_Hwdata(m_Hwdata),
    .Hready_out(Hready_out), .Hresp(Hresp), .Htrans(Htrans), .Haddr(Haddr),
    .Hwrite(Hwrite), .Hwdata(Hwdata), .Hready_in(Hready_in), .Hgrant(Hgrant),
    .Hmaster(Hmaster), .Hmaster_d(Hmaster_d)
  );
  function automatic logic [31:0] obs(sig_e s);
    case (s)
      S_GNT:   return 32'(Hgrant);
      S_M:     return 32'(Hmaster);
      S_MD:    return 32'(Hmaster_d);
      S_TR:    return 32'(Htrans);
      S_ADDR:  return Haddr;
      S_WR:    return 32'(Hwrite);
      S_WD:    return Hwdata;
      S_BEAT:  return 32'(dut.beat_cnt);
      default: return 32'(Hready_in);
    endcase
  endfunction
  task automatic ex(input string tag, input sig_e s, input logic [31:0] v);
    sb.push_back('{tag, s, v});
  endtask
  task automatic st(input string t, input logic [2:0] g, input logic [1:0] m, input logic [1:0] md);
    ex({t, "_gnt"}, S_GNT, 32'(g));
    ex({t, "_hmaster"}, S_M, 32'(m));
    ex({t, "_hmaster_d"}, S_MD, 32'(md));
  endtask
  task automatic check();
    while (sb.size() > 0) begin
      exp_t e;
      logic [31:0] o;
      e = sb.pop_front();
      o = obs(e.s);
      checks++;
      assert (o === e.v) else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", e.tag, o, e.v);
      end
    end
  endtask
  task automatic tick();
    @(posedge Hclk);
    #1;
    check();
  endtask
  task automatic now();
    #1;
    check();
  endtask
  task automatic drv(input logic [2:0] req, input logic [1:0] t0, input logic [1:0] t1, input logic [1:0] t2);
    Hbusreq  = req;
    m_Htrans = {t2, t1, t0};
  endtask
  initial begin
    Hreset = 1; Hready_out = 1; Hresp = HRESP_OKAY; m_Hwrite = 3'b010;
    m_Haddr = {A2, A1, A0}; m_Hwdata = {W2, W1, W0};
    drv(3'b111, NS, NS, NS);
    tick();
    st("rst", 3'b001, 0, 0); ex("rst_trans", S_TR, 0); ex("rst_addr", S_ADDR, A0); ex("rst_beat", S_BEAT, 0);
    tick();
    Hreset = 0; drv(3'b111, I, I, I);
    st("rel", 3'b010, 0, 0); tick();
    st("rel2", 3'b010, 1, 0); tick();
    drv(3'b111, I, NS, I);
    st("rot1", 3'b010, 1, 1); ex("rot1_beat", S_BEAT, 1); tick();
    drv(3'b111, I, I, I);
    st("rot2", 3'b100, 1, 1); tick();
    st("rot3", 3'b100, 2, 1); ex("rot3_beat", S_BEAT, 0); tick();
    drv(3'b111, I, I, NS);
    ex("rot_addr", S_ADDR, A2); ex("rot_trans", S_TR, 32'(NS)); now();
    st("rot4", 3'b100, 2, 2); ex("rot4_beat", S_BEAT, 1); tick();
    drv(3'b111, I, I, I);
    st("rot5", 3'b001, 2, 2); tick();
    st("rot6", 3'b001, 0, 2); tick();
    drv(3'b101, NS, I, I);
    st("bst1", 3'b001, 0, 0); ex("bst1_beat", S_BEAT, 1); tick();
    drv(3'b101, SQ, I, I);
    st("bst2", 3'b001, 0, 0); ex("bst2_beat", S_BEAT, 2); tick();
    st("bst3", 3'b001, 0, 0); ex("bst3_beat", S_BEAT, 3); tick();
    Hready_out = 0;
    for (int i = 0; i < 3; i++) begin
      st("wait", 3'b001, 0, 0); ex("wait_beat", S_BEAT, 3); ex("wait_rdy_in", S_RDY, 0); tick();
    end
    Hready_out = 1;
    st("cap", 3'b100, 0, 0); ex("cap_beat", S_BEAT, 4); tick();
    st("cap2", 3'b100, 2, 0); ex("cap2_beat", S_BEAT, 0); tick();
    drv(3'b101, I, I, NS);
    st("m2", 3'b100, 2, 2); ex("m2_beat", S_BEAT, 1); tick();
    drv(3'b001, I, I, I);
    st("back", 3'b001, 2, 2); tick();
    st("back2", 3'b001, 0, 2); tick();
    drv(3'b110, I, I, I);
    st("d1", 3'b010, 0, 0); tick();
    st("d2", 3'b010, 1, 0); tick();
    drv(3'b100, I, NS, I);
    ex("d_addr1", S_ADDR, A1); ex("d_write1", S_WR, 1); ex("d_trans1", S_TR, 32'(NS)); now();
    st("d3", 3'b100, 1, 1); ex("d3_wdata", S_WD, W1); tick();
    drv(3'b100, I, I, NS);
    st("d4", 3'b100, 2, 1); ex("d4_addr", S_ADDR, A2); ex("d4_wdata", S_WD, W1); ex("d4_write", S_WR, 0); tick();
    drv(3'b000, I, I, I);
    st("idle0", 3'b001, 2, 2); tick();
    for (int i = 0; i < 4; i++) begin
      ex("idle_gnt", S_GNT, 1); ex("idle_trans", S_TR, 0); tick();
    end
    drv(3'b100, I, I, I);
    st("req2", 3'b100, 0, 0); tick();
    drv(3'b100, I, I, NS);
    st("pre", 3'b100, 2, 0); tick();
    Hreset = 1; Hready_out = 0;
    ex("mrst_trans", S_TR, 0); ex("mrst_addr", S_ADDR, A0); ex("mrst_wdata", S_WD, W0); now();
    st("mrst", 3'b001, 0, 0); ex("mrst_beat", S_BEAT, 0); tick();
    Hreset = 0; Hready_out = 1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
